// File: rtl/dice_roller.sv
`default_nettype none
// ============================================================================
// Module      : dice_roller
// Description : Turns a held "roll" level and a die-type selector into a
//               pseudo-random result 1..faces, shown as three BCD digits with
//               leading-zero blanking. The display animates while rolling and
//               freezes on release.
// Revision    : 1.0 - initial release
// ============================================================================
module dice_roller #(
    parameter int ANIM_DIV = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll,
    input  logic [2:0] sel,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic       en0,
    output logic       en1,
    output logic       en2,
    output logic       busy,
    output logic       done
);

    localparam int                  c_ANIM_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [c_ANIM_W-1:0] c_ANIM_LAST = c_ANIM_W'(ANIM_DIV - 1);
    localparam logic [c_ANIM_W-1:0] c_ANIM_ONE  = c_ANIM_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ROLL = 2'd1;
    localparam logic [1:0] c_ST_SHOW = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [6:0]          r_cnt;
    logic [6:0]          r_faces;
    logic [6:0]          r_value;
    logic [c_ANIM_W-1:0] r_anim;
    logic                r_frozen;

    logic [6:0]          w_faces_sel;
    logic [6:0]          w_faces_use;
    logic [6:0]          w_sample;
    logic                w_hund;
    logic [6:0]          w_rem;
    logic [3:0]          w_d0;
    logic [3:0]          w_d1;
    logic [3:0]          w_d2;
    logic                w_en0;
    logic                w_en1;
    logic                w_en2;
    logic                w_busy;

    // Die-type decode; code 7 falls back to a d6.
    always_comb begin
        w_faces_sel = 7'd6;
        case (sel)
            3'd0:    w_faces_sel = 7'd4;
            3'd1:    w_faces_sel = 7'd6;
            3'd2:    w_faces_sel = 7'd8;
            3'd3:    w_faces_sel = 7'd10;
            3'd4:    w_faces_sel = 7'd12;
            3'd5:    w_faces_sel = 7'd20;
            3'd6:    w_faces_sel = 7'd100;
            default: w_faces_sel = 7'd6;
        endcase
    end

    // The selector only steers the die outside a roll; during a roll the latched
    // face count is used. Using the live decode in IDLE/SHOW lets cnt snap back
    // to 1 on the very next edge after the die shrinks.
    assign w_faces_use = (r_state == c_ST_ROLL) ? r_faces : w_faces_sel;
    assign w_sample    = (r_cnt > w_faces_use) ? 7'd1 : r_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: roll level moves into ROLL, release freezes into SHOW.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (roll)  w_state_nxt = c_ST_ROLL;
            c_ST_ROLL: if (!roll) w_state_nxt = c_ST_SHOW;
            c_ST_SHOW: if (roll)  w_state_nxt = c_ST_ROLL;
            default:              w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Free-running counter, face latch, animation timer and result sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= 7'd1;
            r_faces  <= 7'd6;
            r_anim   <= '0;
            r_value  <= 7'd0;
            r_frozen <= 1'b0;
        end else begin
            r_cnt    <= (r_cnt >= w_faces_use) ? 7'd1 : r_cnt + 7'd1;
            r_faces  <= w_faces_use;
            r_frozen <= 1'b0;
            if (r_state != c_ST_ROLL && w_state_nxt == c_ST_ROLL) begin
                r_anim  <= '0;
                r_value <= w_sample;
            end else if (r_state == c_ST_ROLL && w_state_nxt == c_ST_ROLL) begin
                if (r_anim == c_ANIM_LAST) begin
                    r_anim  <= '0;
                    r_value <= w_sample;
                end else begin
                    r_anim <= r_anim + c_ANIM_ONE;
                end
            end else if (r_state == c_ST_ROLL && w_state_nxt == c_ST_SHOW) begin
                r_value  <= w_sample;
                r_frozen <= 1'b1;
            end
        end
    end

    // Output decode: BCD split of the value with leading-zero blanking.
    always_comb begin
        w_hund = (r_value >= 7'd100);
        w_rem  = w_hund ? (r_value - 7'd100) : r_value;
        w_d0   = 4'd0;
        w_d1   = 4'd0;
        w_d2   = 4'd0;
        w_en0  = 1'b0;
        w_en1  = 1'b0;
        w_en2  = 1'b0;
        w_busy = (r_state == c_ST_ROLL);
        if (r_state != c_ST_IDLE) begin
            w_d0  = 4'(w_rem % 7'd10);
            w_d1  = 4'(w_rem / 7'd10);
            w_d2  = {3'd0, w_hund};
            w_en0 = 1'b1;
            w_en1 = (r_value >= 7'd10);
            w_en2 = w_hund;
        end
    end

    // Output register; done follows the freeze edge by one cycle, so it can
    // never coincide with busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            d0   <= 4'd0;
            d1   <= 4'd0;
            d2   <= 4'd0;
            en0  <= 1'b0;
            en1  <= 1'b0;
            en2  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            d0   <= w_d0;
            d1   <= w_d1;
            d2   <= w_d2;
            en0  <= w_en0;
            en1  <= w_en1;
            en2  <= w_en2;
            busy <= w_busy;
            done <= r_frozen;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dice_roller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dice_roller
// Description : Self-checking bench for dice_roller with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dice_roller;

    localparam int ANIM_DIV = 4;
    localparam int S_IDLE = 0;
    localparam int S_ROLL = 1;
    localparam int S_SHOW = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       roll  = 1'b0;
    logic [2:0] sel   = 3'd1;
    logic [3:0] d0, d1, d2;
    logic       en0, en1, en2, busy, done;

    int checks   = 0;
    int failures = 0;

    // Model of the die: state, counter, value and pending freeze.
    int m_state = S_IDLE;
    int m_cnt   = 1;
    int m_value = 0;
    int m_froze = 0;
    int m_since = 0;
    int m_die   = 6;
    int m_froze_die = 6;

    int e_d0, e_d1, e_d2, e_en0, e_en1, e_en2, e_busy, e_done;

    always #5 clk = ~clk;

    dice_roller #(.ANIM_DIV(ANIM_DIV)) dut (
        .clk  (clk),
        .reset(reset),
        .roll (roll),
        .sel  (sel),
        .d0   (d0),
        .d1   (d1),
        .d2   (d2),
        .en0  (en0),
        .en1  (en1),
        .en2  (en2),
        .busy (busy),
        .done (done)
    );

    function automatic int faces_of(input logic [2:0] s);
        case (s)
            3'd0:    return 4;
            3'd1:    return 6;
            3'd2:    return 8;
            3'd3:    return 10;
            3'd4:    return 12;
            3'd5:    return 20;
            3'd6:    return 100;
            default: return 6;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int shown();
        return int'(d2) * 100 + int'(d1) * 10 + int'(d0);
    endfunction

    // One clock: derive expected outputs, advance the model, compare.
    task automatic tick();
        int die, take;
        @(posedge clk);
        if (reset) begin
            {e_d0, e_d1, e_d2, e_en0, e_en1, e_en2, e_busy, e_done} = '0;
        end else begin
            e_busy = (m_state == S_ROLL);
            e_done = m_froze;
            if (m_state == S_IDLE) begin
                {e_d0, e_d1, e_d2, e_en0, e_en1, e_en2} = '0;
            end else begin
                e_d2  = m_value / 100;
                e_d1  = (m_value / 10) % 10;
                e_d0  = m_value % 10;
                e_en0 = 1;
                e_en1 = (m_value >= 10);
                e_en2 = (m_value >= 100);
            end
        end
        if (reset) begin
            m_state = S_IDLE; m_cnt = 1; m_value = 0; m_froze = 0; m_since = 0;
        end else begin
            die  = (m_state == S_ROLL) ? m_die : faces_of(sel);
            take = (m_cnt > die) ? 1 : m_cnt;
            m_froze = 0;
            if (m_state != S_ROLL) begin
                m_die = die;
                if (roll) begin
                    m_state = S_ROLL; m_value = take; m_since = 0;
                end
            end else if (roll) begin
                m_since++;
                if (m_since == ANIM_DIV) begin
                    m_since = 0; m_value = take;
                end
            end else begin
                m_state = S_SHOW; m_value = take; m_froze = 1; m_froze_die = die;
            end
            m_cnt = (m_cnt >= die) ? 1 : m_cnt + 1;
        end
        #1;
        check("d0", d0, e_d0);
        check("d1", d1, e_d1);
        check("d2", d2, e_d2);
        check("en0", en0, e_en0);
        check("en1", en1, e_en1);
        check("en2", en2, e_en2);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("cnt", dut.r_cnt, m_cnt);
        if (done === 1'b1)
            check("result_range", (shown() >= 1 && shown() <= m_froze_die), 1);
    endtask

    // Hold roll until the counter reaches target, then release and let the
    // result reach the display.
    task automatic release_at(input int target);
        for (int i = 0; i < 200 && m_cnt != target; i++) tick();
        check("cnt_reach", dut.r_cnt, target);
        roll = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int wrap_exp[10];
        int last_chg, n_chg, prev_disp, dones;
        wrap_exp = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};

        // Reset state
        tick();
        tick();

        // d6 roll released at cnt=4
        reset = 1'b0;
        roll  = 1'b1;
        repeat ($urandom_range(3, 12)) tick();
        release_at(4);
        check("d6_d0", d0, 4);
        check("d6_en0", en0, 1);
        check("d6_en1", en1, 0);
        check("d6_en2", en2, 0);
        check("d6_done", done, 1);
        dones = 0;
        repeat (3) begin
            tick();
            dones += int'(done);
            check("d6_busy_after", busy, 0);
        end
        check("d6_done_once", dones, 0);

        // d100 boundary and single-digit result
        sel  = 3'd6;
        roll = 1'b1;
        tick();
        release_at(100);
        check("d100_d2", d2, 1);
        check("d100_d1", d1, 0);
        check("d100_d0", d0, 0);
        check("d100_en", {en2, en1, en0}, 3'b111);
        roll = 1'b1;
        tick();
        release_at(9);
        check("d100_9_d0", d0, 9);
        check("d100_9_en1", en1, 0);
        check("d100_9_en2", en2, 0);

        // sel change in SHOW pulls cnt back to 1 on the next edge
        for (int i = 0; i < 120 && m_cnt != 57; i++) tick();
        check("show_cnt57", dut.r_cnt, 57);
        sel = 3'd0;
        tick();
        check("sel_cnt1", dut.r_cnt, 1);
        roll = 1'b1;
        repeat (3) tick();
        sel = 3'd6;
        repeat (8) begin
            tick();
            check("roll_faces_kept", dut.r_cnt <= 7'd4, 1);
        end
        roll = 1'b0;
        tick();
        tick();
        check("roll_faces_result", (shown() >= 1 && shown() <= 4), 1);

        // Wrap-around on a d4 from reset
        sel   = 3'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrap_0", dut.r_cnt, wrap_exp[0]);
        for (int i = 1; i < 10; i++) begin
            tick();
            check("wrap_seq", dut.r_cnt, wrap_exp[i]);
        end
        repeat (4) begin
            roll = 1'b1;
            repeat ($urandom_range(2, 9)) tick();
            roll = 1'b0;
            tick();
            tick();
            check("d4_range", (d0 != 4'd0 && d0 <= 4'd4), 1);
        end

        // d20 released at 10
        sel  = 3'd5;
        roll = 1'b1;
        tick();
        release_at(10);
        check("d20_d1", d1, 1);
        check("d20_d0", d0, 0);
        check("d20_en1", en1, 1);

        // Animation: display refreshes every ANIM_DIV cycles while held
        roll      = 1'b1;
        prev_disp = shown();
        last_chg  = 0;
        n_chg     = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c > 1) check("anim_busy", busy, 1);
            if (shown() != prev_disp) begin
                if (n_chg > 0) check("anim_interval", c - last_chg, ANIM_DIV);
                n_chg++;
                last_chg  = c;
                prev_disp = shown();
            end
        end
        check("anim_changed", n_chg >= 4, 1);
        roll = 1'b0;
        tick();
        tick();

        // Reset mid-roll
        roll = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("rst_en", {en2, en1, en0}, 3'b000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", dut.r_cnt, 1);
        reset = 1'b0;
        tick();
        check("rst_idle_out", {busy, en0}, 2'b00);
        release_at(7);
        check("rst_roll_d0", d0, 7);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) roll = ~roll;
            if ($urandom_range(0, 15) == 0) sel = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dice_roller.md
Name: dice_roller

Overview:
Upstream stage of the seven-segment decoders. It turns a "roll" button level and a die-type selector into a pseudo-random result, 1..faces. The result is presented as three 4-bit BCD digits (units, tens, hundreds), each with its own display enable, and each digit/enable pair drives one decoder instance. While the button is held, the displayed value animates; on release, the result is frozen.

Parameters:
ANIM_DIV, 2500000, clock cycles between animation display refreshes while rolling (bench overrides to 4)

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
roll  input  1  roll request level, already synchronised and debounced upstream; high = rolling
sel  input  3  die type: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6=d100, 7=d6
d0  output  4  units BCD digit
d1  output  4  tens BCD digit
d2  output  4  hundreds BCD digit
en0  output  1  units display enable
en1  output  1  tens display enable
en2  output  1  hundreds display enable
busy  output  1  high while in ROLL
done  output  1  one-cycle pulse when a result is frozen

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=IDLE, cnt=1, anim=0, value=0.
  - d0=d1=d2=0, en0=en1=en2=0, busy=0, done=0.
  - Reset has priority over everything, including mid-ROLL; the next rolling edge after reset shows IDLE outputs.
- faces register:
  - Decoded from sel every cycle while in IDLE or SHOW.
  - Frozen while in ROLL; sel changes during ROLL are ignored.
- cnt (7-bit):
  - Free-runs every non-reset cycle in every state.
  - cnt <= (cnt >= faces) ? 1 : cnt+1.
  - If faces shrinks below cnt (sel change in IDLE/SHOW), cnt returns to 1 on the next cycle, never exceeding faces for more than that one cycle.
  - A frozen result is always in 1..faces: it is clamped to 1 if cnt > faces at sample time.
- FSM:
  - IDLE: all enables 0. roll=1 -> ROLL.
  - ROLL:
    - Entry cycle: anim<=0 and value<=cnt.
    - Then anim increments each cycle; when anim==ANIM_DIV-1, anim<=0 and value<=cnt.
    - busy=1.
    - roll=0 -> SHOW, value<=cnt (the cnt seen in the cycle roll is sampled low), done=1 for exactly the following cycle.
  - SHOW: value held, busy=0. roll=1 -> ROLL (new roll).
- Display path, registered one cycle after value updates:
  - value (0..100) converted to BCD: d2=value/100, d1=(value/10)%10, d0=value%10.
  - Leading-zero blanking, in ROLL or SHOW:
    - en0=1.
    - en1=(value>=10).
    - en2=(value>=100).
  - In IDLE: all enables 0, digits 0.
- Latency: roll low sampled at edge N -> state SHOW and value valid after edge N; digits/enables and done valid after edge N+1.
- done never asserts in IDLE or on reset; busy and done are never simultaneously high.

Test Plan:
- d6 roll:
  - Stimulus: sel=1; release reset; roll=1 for some cycles; roll=0 in a cycle where cnt=4.
  - Required response: d0=4, en0=1, en1=0, en2=0; done high exactly one cycle; busy 0 thereafter.
- d100 boundary:
  - Stimulus: sel=6; release roll when cnt=100.
  - Required response: d2=1, d1=0, d0=0, en2=en1=en0=1.
  - Second run: release at cnt=9 -> d0=9, en1=0, en2=0.
- Wrap-around:
  - Stimulus: sel=0 (d4), observe cnt over 10 cycles from reset.
  - Required response: sequence 1,2,3,4,1,2,3,4,1,2; result is never 0 or 5.
  - Then sel=5 (d20): roll released at cnt=10 -> d1=1, d0=0, en1=1.
- Animation:
  - Stimulus: ANIM_DIV=4; hold roll 20 cycles with sel=5.
  - Required response: displayed value changes only every 4 cycles and equals cnt at each refresh edge; busy=1 throughout.
- sel change:
  - Stimulus: in SHOW with sel=6 and cnt=57, set sel=0.
  - Required response: cnt=1 next cycle; in a subsequent ROLL, a sel toggle mid-roll does not alter the faces in use.
- Reset mid-roll:
  - Stimulus: assert reset during ROLL.
  - Required response: next cycle enables=0, busy=0, done=0, cnt=1; a roll after reset release behaves as from IDLE.
